// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and error codes for the ALU command sequencer
package alu_seq_pkg;

    // ALU opcodes; OP_DIV and OP_MOD are the ones that trap on y == 0
    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_SUB  = 8'd1;
    localparam logic [7:0] OP_MUL  = 8'd2;
    localparam logic [7:0] OP_DIV  = 8'd3;
    localparam logic [7:0] OP_AND  = 8'd4;
    localparam logic [7:0] OP_OR   = 8'd5;
    localparam logic [7:0] OP_XOR  = 8'd6;
    localparam logic [7:0] OP_NOT  = 8'd7;
    localparam logic [7:0] OP_NAND = 8'd8;
    localparam logic [7:0] OP_NOR  = 8'd9;
    localparam logic [7:0] OP_MOD  = 8'd10;
    localparam logic [7:0] OP_SHL  = 8'd11;
    localparam logic [7:0] OP_SHR  = 8'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPND = 2'd1,
        EXEC = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_DIV0    = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

endpackage

// File: rtl/strobe_sync_edge.sv
// rtl/strobe_sync_edge.sv - multi-flop synchronizer with rising-edge pulse output
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   async_in    : asynchronous level input
//   edge_pulse  : one-cycle pulse when the synchronized level goes 0 -> 1
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - two-byte command assembler driving a combinational 4-bit ALU
//
// Optional feature macro: ALU_SEQ_CHAIN_EN (opcode bit 7 chains x from the previous result)
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ena                   : block enable; low freezes the FSM and ignores strobes
//   in_data, in_strobe    : command byte and its asynchronous strobe
//   alu_opcode            : opcode bus to the ALU
//   alu_operands          : {y, x} operand bus to the ALU
//   alu_result            : combinational ALU result
//   res_data, res_valid   : captured result, held until res_ready handshake
//   res_ready             : consumer accept
//   busy                  : command executing or result waiting
//   err_pulse, err_code   : one-cycle error strobe and sticky last error cause
module alu_op_sequencer #(
    parameter int MAX_OPCODE  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_strobe,
    output logic [7:0] alu_opcode,
    output logic [7:0] alu_operands,
    input  logic [7:0] alu_result,
    output logic [7:0] res_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       busy,
    output logic       err_pulse,
    output logic [1:0] err_code
);

    import alu_seq_pkg::*;

    seq_state_t state, state_n;
    logic       strobe_edge;
    logic       accepted;
    logic       opc_bad;
    logic       div0;
    logic       ld_opc, ld_opnd, capture, consume, err_set;
    logic [1:0] err_val;

    strobe_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (in_strobe),
        .edge_pulse (strobe_edge)
    );

    // Edges arriving while disabled are simply lost.
    assign accepted = strobe_edge & ena;

`ifdef ALU_SEQ_CHAIN_EN
    logic       chain_q;
    // Only the low nibble of the previous result can become a chained x.
    logic [3:0] prev_result;
    assign opc_bad = {1'b0, in_data[6:0]} > 8'(MAX_OPCODE);
`else
    // Bit 7 is part of the opcode here, so any opcode with it set is out of range.
    assign opc_bad = in_data > 8'(MAX_OPCODE);
`endif

    assign div0 = ((alu_opcode == OP_DIV) || (alu_opcode == OP_MOD)) && (alu_operands[7:4] == 4'd0);
    assign busy = (state == EXEC) || (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        ld_opc  = 1'b0;
        ld_opnd = 1'b0;
        capture = 1'b0;
        consume = 1'b0;
        err_set = 1'b0;
        err_val = ERR_NONE;
        case (state)
            IDLE: begin
                if (accepted) begin
                    if (opc_bad) begin
                        err_set = 1'b1;
                        err_val = ERR_OPCODE;
                    end else begin
                        ld_opc  = 1'b1;
                        state_n = OPND;
                    end
                end
            end
            OPND: begin
                if (accepted) begin
                    ld_opnd = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (ena) begin
                    capture = 1'b1;
                    state_n = HOLD;
                    if (div0) begin
                        err_set = 1'b1;
                        err_val = ERR_DIV0;
                    end
                end
                // A simultaneous overrun is reported in preference to divide-by-zero.
                if (accepted) begin
                    err_set = 1'b1;
                    err_val = ERR_OVERRUN;
                end
            end
            HOLD: begin
                // The handshake is not gated by ena so a consumer can always drain.
                if (res_valid && res_ready) begin
                    consume = 1'b1;
                    state_n = IDLE;
                end
                if (accepted) begin
                    err_set = 1'b1;
                    err_val = ERR_OVERRUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode   <= 8'h00;
            alu_operands <= 8'h00;
            res_data     <= 8'h00;
            res_valid    <= 1'b0;
            err_pulse    <= 1'b0;
            err_code     <= ERR_NONE;
`ifdef ALU_SEQ_CHAIN_EN
            chain_q      <= 1'b0;
            prev_result  <= 4'h0;
`endif
        end else begin
            err_pulse <= err_set;
            if (err_set) err_code <= err_val;
            if (ld_opc) begin
`ifdef ALU_SEQ_CHAIN_EN
                alu_opcode <= {1'b0, in_data[6:0]};
                chain_q    <= in_data[7];
`else
                alu_opcode <= in_data;
`endif
            end
            if (ld_opnd) begin
`ifdef ALU_SEQ_CHAIN_EN
                alu_operands <= chain_q ? {in_data[3:0], prev_result} : in_data;
`else
                alu_operands <= in_data;
`endif
            end
            if (capture) begin
                res_data  <= div0 ? 8'h00 : alu_result;
                res_valid <= 1'b1;
            end
            if (consume) begin
                res_valid <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
                prev_result <= res_data[3:0];
`endif
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream command sequencer for the 4-bit ALU. It assembles a two-byte command (opcode, then packed operands) from a strobed byte input. It presents stable opcode and operand buses to the combinational ALU, captures the ALU result one cycle later and holds it on a valid/ready output until consumed. It also flags bad opcodes, divide-by-zero and overrun.

## Interface
- MAX_OPCODE, 12: highest legal opcode; larger values are rejected.
- SYNC_STAGES, 2: synchronizer flops on in_strobe (minimum 2).
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  high = block active; low = strobes ignored, all state held
- in_data  in  8  command byte, sampled on the accepted strobe edge
- in_strobe  in  1  asynchronous byte strobe (pushbutton level); each rising edge = one byte
- alu_opcode  out  8  opcode to ALU (its uio_in)
- alu_operands  out  8  {y[3:0], x[3:0]} to ALU (its ui_in)
- alu_result  in  8  combinational ALU result
- res_data  out  8  captured result
- res_valid  out  1  res_data valid, held until handshake
- res_ready  in  1  consumer accepts res_data when res_valid & res_ready at a clk edge
- busy  out  1  high in EXEC and HOLD
- err_pulse  out  1  one-cycle error strobe
- err_code  out  2  0 none, 1 bad opcode, 2 divide by zero, 3 overrun; holds last cause until next error or reset

## Operation
- in_strobe passes through SYNC_STAGES flops. The byte is accepted on a synchronized rising edge (sync high, previous low) while ena=1.
- States:
  - IDLE: accepted byte = opcode. If opcode[6:0] > MAX_OPCODE → err_pulse, err_code=1, stay IDLE. Else latch alu_opcode and go to OPND.
  - OPND: accepted byte latched into alu_operands → EXEC.
  - EXEC (one cycle): res_data ← alu_result, res_valid ← 1 → HOLD.
  - HOLD: on res_valid & res_ready → res_valid ← 0, store res_data as prev_result → IDLE.
- Divide by zero: opcode 3 or 10 with y=0 → in EXEC, res_data forced to 8'h00, err_pulse, err_code=2. The result is still delivered normally.
- Accepted strobe edge in EXEC or HOLD: byte dropped, err_pulse, err_code=3, state unchanged. This includes a strobe coincident with the HOLD handshake.
- alu_opcode and alu_operands hold their values until overwritten. They are not cleared on return to IDLE.
- ena=0: no byte accepted, FSM frozen, handshake still completes in HOLD. The synchronizer keeps running, so an edge seen while ena=0 is lost.

## Timing
- Reset values: alu_opcode=0, alu_operands=0, res_data=0, res_valid=0, busy=0, err_pulse=0, err_code=0, prev_result=0, state IDLE, synchronizer flops 0.
- Operand byte accepted at edge k → alu_operands valid after k. Edge k+1 captures the result, so res_valid=1 after k+1.
- Latency from in_strobe rising (setup-meeting) to res_valid: SYNC_STAGES+2 edges.
- err_pulse: high exactly one cycle, in the cycle after the offending edge.
- rst_n low mid-operation: immediate return to reset values. A partially assembled command is discarded.
- Minimum spacing between bytes: strobe must be low for at least one synchronized sample.

## Configuration
- ALU_SEQ_CHAIN_EN defined: opcode bit 7 = chain flag.
  - Chained command: the operand byte supplies only y (in_data[3:0]); x = prev_result[3:0].
  - Opcode range check uses bits [6:0].
  - alu_opcode is driven with bit 7 cleared.
- Undefined: bit 7 is part of the opcode, so any opcode with bit 7 set is rejected as bad (err_code=1). prev_result register is not built.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode localparams (OP_ADD=0 … OP_SHR=12, OP_DIV=3, OP_MOD=10)
  - state enum {IDLE, OPND, EXEC, HOLD}
  - err_code localparams (ERR_NONE, ERR_OPCODE, ERR_DIV0, ERR_OVERRUN)
- Sub-module strobe_sync_edge: SYNC_STAGES synchronizer plus rising-edge detect, output one-cycle pulse.

## Test plan
- Opcode 8'h00, operands 8'h53 → alu_operands=8'h53, res_data=8'h08, res_valid until res_ready, err_code=0.
- Opcode 8'h03, operands 8'h07 (y=0) → res_data=8'h00, err_pulse one cycle, err_code=2, result still delivered.
- Opcode 8'h0D → err_pulse, err_code=1, state stays IDLE; next byte 8'h00 is treated as opcode.
- During HOLD with res_ready=0, send byte 8'hFF → err_code=3, res_data unchanged, no state change.
- With ALU_SEQ_CHAIN_EN, after consumed result 8'h08: opcode 8'h80, byte 8'h02 → alu_operands=8'h28, res_data=8'h0A. Without the macro, opcode 8'h80 → err_code=1.
- rst_n pulsed low in OPND and in HOLD → all outputs at reset values immediately; a fresh command afterwards completes normally.
